// File: rtl/cmd_frame_sender_pkg.sv
// Constants and state encodings shared by the UART transmit path.
package cmd_frame_sender_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;
  localparam int SB_TICK_DEF = 16;
  localparam int OVERSAMPLE  = 16;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_SEND_A,
    SEQ_SEND_B,
    SEQ_SEND_OP
  } seq_state_t;

endpackage

// File: rtl/cmd_frame_sender_serializer.sv
// 8N1 frame serializer driven by the 16x oversampling baud tick.
module uart_frame_serializer
  import cmd_frame_sender_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_s_tick,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_byte,
  output logic               o_tx,
  output logic               o_stop_last,
  output logic               o_stop_done
);

  localparam int              NB_N      = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [3:0]      TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]      STOP_LAST = 4'(SB_TICK - 1);
  localparam logic [NB_N-1:0] BIT_LAST  = NB_N'(NB_DATA - 1);

  ser_state_t         r_state;
  logic [3:0]         r_s;
  logic [NB_N-1:0]    r_n;
  logic [NB_DATA-1:0] r_shreg;
  logic               r_tx;
  logic               r_done;

  // Lets the sequencer react on the very edge the stop bit ends.
  assign o_stop_last = (r_state == SER_STOP) && i_s_tick && (r_s == STOP_LAST);
  assign o_tx        = r_tx;
  assign o_stop_done = r_done;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= SER_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_shreg <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        SER_IDLE: begin
          if (i_load) begin
            r_state <= SER_START;
            r_s     <= '0;
            r_n     <= '0;
            r_shreg <= i_byte;
            r_tx    <= 1'b0;
          end
        end
        SER_START: begin
          if (i_s_tick) begin
            if (r_s == TICK_LAST) begin
              r_s     <= '0;
              r_state <= SER_DATA;
              r_tx    <= r_shreg[0];
            end else begin
              r_s <= r_s + 4'd1;
            end
          end
        end
        SER_DATA: begin
          if (i_s_tick) begin
            if (r_s == TICK_LAST) begin
              r_s     <= '0;
              r_shreg <= r_shreg >> 1;
              if (r_n == BIT_LAST) begin
                r_state <= SER_STOP;
                r_tx    <= 1'b1;
              end else begin
                r_n  <= r_n + NB_N'(1);
                r_tx <= r_shreg[1];
              end
            end else begin
              r_s <= r_s + 4'd1;
            end
          end
        end
        SER_STOP: begin
          if (i_s_tick) begin
            if (r_s == STOP_LAST) begin
              r_state <= SER_IDLE;
              r_s     <= '0;
              r_done  <= 1'b1;
            end else begin
              r_s <= r_s + 4'd1;
            end
          end
        end
        default: r_state <= SER_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cmd_frame_sender.sv
// Command initiator: latches A, B and opcode, then sends them as three
// back-to-back 8N1 frames.
module cmd_frame_sender
  import cmd_frame_sender_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_s_tick,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  input  logic [NB_OP-1:0]   i_operation,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_byte_done_tick,
  output logic               o_done_tick
);

  seq_state_t         r_state;
  logic [NB_DATA-1:0] r_b;
  logic [NB_DATA-1:0] r_op;
  logic               r_busy;
  logic               r_done;

  logic               w_load;
  logic [NB_DATA-1:0] w_byte;
  logic               w_stop_last;
  logic               w_stop_done;

  // Operand A goes straight into the serializer so its start bit can begin
  // the cycle after acceptance; later frames reload on the previous stop-done.
  always_comb begin
    w_load = 1'b0;
    w_byte = i_data_a;
    case (r_state)
      SEQ_IDLE:    w_load = i_start;
      SEQ_SEND_B:  begin w_load = w_stop_done; w_byte = r_b;  end
      SEQ_SEND_OP: begin w_load = w_stop_done; w_byte = r_op; end
      default:     w_load = 1'b0;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= SEQ_IDLE;
      r_b     <= '0;
      r_op    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        SEQ_IDLE: begin
          if (i_start) begin
            r_state <= SEQ_SEND_A;
            r_busy  <= 1'b1;
            r_b     <= i_data_b;
            r_op    <= NB_DATA'(i_operation);
          end
        end
        SEQ_SEND_A:  if (w_stop_last) r_state <= SEQ_SEND_B;
        SEQ_SEND_B:  if (w_stop_last) r_state <= SEQ_SEND_OP;
        SEQ_SEND_OP: begin
          if (w_stop_last) begin
            r_state <= SEQ_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= SEQ_IDLE;
      endcase
    end
  end

  uart_frame_serializer #(
    .NB_DATA(NB_DATA),
    .SB_TICK(SB_TICK)
  ) u_serializer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_s_tick   (i_s_tick),
    .i_load     (w_load),
    .i_byte     (w_byte),
    .o_tx       (o_tx),
    .o_stop_last(w_stop_last),
    .o_stop_done(w_stop_done)
  );

  assign o_busy           = r_busy;
  assign o_done_tick      = r_done;
  assign o_byte_done_tick = w_stop_done;

endmodule

// File: tb/tb_cmd_frame_sender.sv
// Self-checking bench: a line decoder pops expected bytes from a scoreboard.
module tb_cmd_frame_sender;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_tick = 1'b0;
  logic       start = 1'b0;
  logic [7:0] da = 8'h00;
  logic [7:0] db = 8'h00;
  logic [5:0] op = 6'h00;
  logic       tx, busy, bdone, done;

  always #5 clk = ~clk;

  cmd_frame_sender dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_s_tick        (s_tick),
    .i_start         (start),
    .i_data_a        (da),
    .i_data_b        (db),
    .i_operation     (op),
    .o_tx            (tx),
    .o_busy          (busy),
    .o_byte_done_tick(bdone),
    .o_done_tick     (done)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         frames_rx = 0;
  bit         tick_en = 1'b1;
  int         div = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Baud tick: one pulse every 4 clocks, changed just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      div    = 0;
      s_tick = 1'b0;
    end else begin
      div    = (div + 1) % 4;
      s_tick = tick_en && (div == 0);
    end
  end

  // Line decoder: samples each bit near its middle (tick 8, 24, ...).
  bit         m_active = 1'b0;
  int         m_ticks = 0;
  logic [9:0] m_frame = '0;
  always @(negedge clk) begin
    if (rst) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (tx === 1'b0) begin
        m_active = 1'b1;
        m_ticks  = 0;
        m_frame  = '0;
      end
    end else if (s_tick) begin
      m_ticks++;
      if (m_ticks >= 8 && ((m_ticks - 8) % 16) == 0) begin
        m_frame[(m_ticks - 8) / 16] = tx;
        if ((m_ticks - 8) / 16 == 9) begin
          m_active = 1'b0;
          frames_rx++;
          if (exp_q.size() == 0) check("unexpected_frame", 32'(m_frame), 32'h3ff);
          else check("frame", 32'(m_frame), 32'({1'b1, exp_q.pop_front(), 1'b0}));
        end
      end
    end
  end

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b,
                          input logic [5:0] o, input logic [7:0] eo);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(eo);
    da = a; db = b; op = o; start = 1'b1;
    @(negedge clk);
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_tx", 32'(tx), 32'd0);
    start = 1'b0;
  endtask

  // Counts ticks/byte-done pulses from the current negedge until target ticks.
  task automatic run_ticks(input int target, output int t, output int bd);
    t = 0; bd = 0;
    for (int c = 0; c < 20000; c++) begin
      if (bdone) bd++;
      if (s_tick) t++;
      if (t >= target) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int t0, input int b0, output int t, output int bd);
    bit ok;
    t = t0; bd = b0; ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (bdone) bd++;
      if (done) begin ok = 1'b1; break; end
      if (s_tick) t++;
      @(negedge clk);
    end
    if (!ok) check("done_timeout", 32'd0, 32'd1);
    else check("busy_low_at_done", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] exp_op;
  } vec_t;
  vec_t vecs[3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, bd, f0, pulses, bad;
    vecs[0] = '{a: 8'h5A, b: 8'h3C, op: 6'b100000, exp_op: 8'h20};
    vecs[1] = '{a: 8'hA5, b: 8'hC3, op: 6'b111111, exp_op: 8'h3F};
    vecs[2] = '{a: 8'h00, b: 8'hFF, op: 6'b000001, exp_op: 8'h01};

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_bdone", 32'(bdone), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    foreach (vecs[i]) begin
      f0 = frames_rx;
      send_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_op);
      wait_done(0, 0, t, bd);
      check("cmd_ticks", 32'(t), 32'd480);
      check("cmd_byte_dones", 32'(bd), 32'd3);
      repeat (20) @(negedge clk);
      check("cmd_frames", 32'(frames_rx - f0), 32'd3);
      check("cmd_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    // Restart attempt while the B frame is in flight must be ignored.
    f0 = frames_rx;
    send_cmd(8'h11, 8'h22, 6'h33, 8'h33);
    run_ticks(240, t, bd);
    da = 8'hFF; start = 1'b1;
    @(negedge clk);
    check("repulse_busy", 32'(busy), 32'd1);
    start = 1'b0; da = 8'h11;
    wait_done(t, bd, t, bd);
    check("repulse_ticks", 32'(t), 32'd480);
    check("repulse_byte_dones", 32'(bd), 32'd3);
    repeat (800) @(negedge clk);
    check("repulse_frames", 32'(frames_rx - f0), 32'd3);
    check("repulse_idle_busy", 32'(busy), 32'd0);

    // Start held high: second command starts right after the first done pulse.
    f0 = frames_rx;
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    send_cmd(8'h01, 8'h02, 6'h03, 8'h03);
    start = 1'b1;
    wait_done(0, 0, t, bd);
    check("b2b_first_ticks", 32'(t), 32'd480);
    @(negedge clk);
    check("b2b_tx", 32'(tx), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(0, 0, t, bd);
    check("b2b_second_ticks", 32'(t), 32'd480);
    check("b2b_second_bdones", 32'(bd), 32'd3);
    repeat (20) @(negedge clk);
    check("b2b_frames", 32'(frames_rx - f0), 32'd6);
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset during data bit 3 of B (B[3]=0, so the line is low there).
    send_cmd(8'h81, 8'hF0, 6'h05, 8'h05);
    run_ticks(232, t, bd);
    check("pre_rst_tx", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_async_tx", 32'(tx), 32'd1);
    check("rst_async_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done || bdone) pulses++;
    end
    check("post_rst_pulses", 32'(pulses), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    f0 = frames_rx;
    send_cmd(vecs[0].a, vecs[0].b, vecs[0].op, vecs[0].exp_op);
    wait_done(0, 0, t, bd);
    check("post_rst_ticks", 32'(t), 32'd480);
    repeat (20) @(negedge clk);
    check("post_rst_frames", 32'(frames_rx - f0), 32'd3);

    // Baud tick stalled for 1000 cycles in the middle of the start bit.
    send_cmd(8'hC3, 8'h5A, 6'h15, 8'h15);
    run_ticks(5, t, bd);
    tick_en = 1'b0;
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (tx !== 1'b0 || busy !== 1'b1 || done || bdone) bad++;
    end
    check("stall_hold", 32'(bad), 32'd0);
    tick_en = 1'b1;
    wait_done(t, bd, t, bd);
    check("stall_ticks", 32'(t), 32'd480);
    check("stall_bdones", 32'(bd), 32'd3);
    repeat (20) @(negedge clk);
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
